// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Contents: FSM state encoding, default operand width, and the helper
// that sizes the bit counter from the operand width.
package mult_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_INIT  = 3'b001,
        ST_ADD   = 3'b010,
        ST_SHIFT = 3'b011,
        ST_DONE  = 3'b100
    } state_t;

    // Counter must hold WIDTH-1; keep at least one bit for WIDTH=1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_controller.sv
// Control FSM for the shift-and-add multiplier.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          operation request (sampled in IDLE, must drop in INIT)
//   cnt_zero       bit counter has reached zero
//   mp_lsb         current multiplier LSB, selects add vs. skip
//   ld_op          load operands / clear accumulator / preset counter
//   ld_acc         add multiplicand into accumulator
//   sh_p           shift {C,ACC,MP} right by one
//   ld_prod        transfer {ACC,MP} to the product register
//   cnt_en         decrement the bit counter
//   busy           registered, high in every state except IDLE
//   done           registered, high for exactly the DONE cycle
module mult_controller
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cnt_zero,
    input  logic mp_lsb,
    output logic ld_op,
    output logic ld_acc,
    output logic sh_p,
    output logic ld_prod,
    output logic cnt_en,
    output logic busy,
    output logic done
);

    state_t state;
    state_t next_state;

    // State and status registers; busy/done track the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != ST_IDLE);
            done  <= (next_state == ST_DONE);
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        next_state = state;
        ld_op      = 1'b0;
        ld_acc     = 1'b0;
        sh_p       = 1'b0;
        ld_prod    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    ld_op      = 1'b1;
                    next_state = ST_INIT;
                end
            end
            // Hold here until the requester releases start.
            ST_INIT: begin
                if (!start) next_state = ST_ADD;
            end
            ST_ADD: begin
                ld_acc     = mp_lsb;
                next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_p = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_DONE;
                end else begin
                    cnt_en     = 1'b1;
                    next_state = ST_ADD;
                end
            end
            ST_DONE: begin
                ld_prod    = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per ADD/SHIFT
// pair, start/done handshake shared with the restoring divider.
// Optional feature: define SEQ_MULT_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied, the product is negated when signs differ).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      request, operands sampled on the first IDLE cycle it is high
//   mcand      multiplicand, WIDTH bits
//   mplier     multiplier, WIDTH bits
//   product    2*WIDTH result, loaded in DONE, held until next DONE or rst
//   busy       high whenever the engine is not IDLE
//   done       one-cycle completion pulse
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mp;
    logic             c;
    logic [CW-1:0]    cnt;

    logic ld_op, ld_acc, sh_p, ld_prod, cnt_en;
    logic cnt_zero;

    logic [WIDTH-1:0] mcand_mag;
    logic [WIDTH-1:0] mplier_mag;
    logic [PW-1:0]    prod_val;

`ifdef SEQ_MULT_SIGNED_EN
    logic sign;

    // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
    assign mcand_mag  = mcand[WIDTH-1]  ? (~mcand  + WIDTH'(1)) : mcand;
    assign mplier_mag = mplier[WIDTH-1] ? (~mplier + WIDTH'(1)) : mplier;
    assign prod_val   = sign ? (~{acc, mp} + PW'(1)) : {acc, mp};

    always_ff @(posedge clk) begin
        if (rst)        sign <= 1'b0;
        else if (ld_op) sign <= mcand[WIDTH-1] ^ mplier[WIDTH-1];
    end
`else
    assign mcand_mag  = mcand;
    assign mplier_mag = mplier;
    assign prod_val   = {acc, mp};
`endif

    assign cnt_zero = (cnt == '0);

    // Datapath registers; the controller guarantees one strobe per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc      <= '0;
            acc     <= '0;
            mp      <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (ld_op) begin
                mc  <= mcand_mag;
                mp  <= mplier_mag;
                acc <= '0;
                c   <= 1'b0;
                cnt <= CW'(WIDTH - 1);
            end
            if (ld_acc) begin
                {c, acc} <= {1'b0, acc} + {1'b0, mc};
            end
            // Logical right shift of {C,ACC,MP}; the add carry re-enters ACC.
            if (sh_p) begin
                acc <= {c, acc[WIDTH-1:1]};
                mp  <= {acc[0], mp[WIDTH-1:1]};
                c   <= 1'b0;
            end
            if (cnt_en) begin
                cnt <= cnt - CW'(1);
            end
            if (ld_prod) begin
                product <= prod_val;
            end
        end
    end

    mult_controller u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cnt_zero (cnt_zero),
        .mp_lsb   (mp[0]),
        .ld_op    (ld_op),
        .ld_acc   (ld_acc),
        .sh_p     (sh_p),
        .ld_prod  (ld_prod),
        .cnt_en   (cnt_en),
        .busy     (busy),
        .done     (done)
    );

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier. It is the inverse-operation companion to the restoring divider.
- Same start/done handshake as the divider: pulse `start`, wait for a one-cycle `done`.
- One bit is processed per two-cycle add/shift step. It is used wherever the datapath rebuilds dividend = quotient*divisor + remainder, or needs an area-cheap product.

Parameters:
- WIDTH, 8, operand width in bits. Product is 2*WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request. Operands are sampled on the first IDLE cycle it is seen high.
- mcand  in  WIDTH  multiplicand
- mplier  in  WIDTH  multiplier
- product  out  2*WIDTH  result register. Loaded in DONE, held until the next DONE or rst.
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, asserted while in DONE

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset: on any clk edge with rst=1, state goes to IDLE, product=0, done=0, busy=0, internal regs=0. Reset mid-operation aborts with no partial result.
- States (3-bit encoding):
  - IDLE=000
  - INIT=001
  - ADD=010
  - SHIFT=011
  - DONE=100
  - Unused codes go to IDLE.
- IDLE:
  - start=1: latch mcand into MC, mplier into low half of P={ACC,MP}, ACC=0, carry C=0, counter=WIDTH-1; next INIT.
  - Else stay.
- INIT: stay while start=1. Operands are not re-sampled. Go to ADD when start=0.
- ADD: if MP[0]=1, {C,ACC} = ACC + MC (WIDTH+1-bit sum); else unchanged. Next SHIFT.
- SHIFT:
  - {C,ACC,MP} logical right shift by 1; C becomes 0.
  - If counter==0, next DONE; else counter decrements, next ADD.
- DONE: product={ACC,MP}, done=1 for exactly this cycle; next IDLE.
- Latency: the first ADD is the cycle after start is seen low in INIT. done rises 2*WIDTH cycles after the first ADD cycle (17th state cycle from first ADD for WIDTH=8).
- Back-to-back: start high during the DONE cycle is ignored; it is recognised in the following IDLE cycle.
- start in ADD/SHIFT/DONE: ignored. Operand changes after sampling: ignored.
- No overflow is possible; the full 2*WIDTH product is exact.

Optional Feature:
- Macro SEQ_MULT_SIGNED_EN.
- Defined: operands are two's complement.
  - IDLE latches |mcand| and |mplier| and a sign flag s = mcand[MSB]^mplier[MSB].
  - DONE loads product = s ? -{ACC,MP} : {ACC,MP}.
  - -2^(WIDTH-1) magnitude is handled as an unsigned WIDTH-bit value (no loss).
  - Latency unchanged.
- Undefined: unsigned only, sign logic absent.

Decomposition:
- Shared package mult_pkg:
  - state encoding constants (IDLE..DONE)
  - default WIDTH
  - counter width = clog2(WIDTH)
- One sub-module, mult_controller: FSM plus counter. It emits ld_op, ld_acc, sh_p, ld_prod, cnt_en, busy, done and takes start, cnt_zero, mp_lsb.
- seq_multiplier keeps the datapath registers and instantiates mult_controller, matching the divider's controller/datapath split.

Test Plan:
- WIDTH=8, mcand=13, mplier=11, start high 1 cycle → product=0x008F, done pulse exactly 16 cycles after the first ADD cycle, busy low afterwards.
- mcand=255, mplier=255 → product=0xFE01. Checks carry into ACC on every add.
- mcand=0, mplier=200, then mcand=200, mplier=0 back-to-back (second start issued the cycle after done) → both products 0x0000; second done 2*WIDTH+2 cycles after second start.
- Start held high 5 cycles, operands changed while high → sampled values are used; ADD begins the cycle after start falls.
- rst asserted mid-run (after 6 SHIFTs) → next cycle busy=0, done=0, product=0. A new run of 7*9 → 0x003F.
- SEQ_MULT_SIGNED_EN: -3*5 → 0xFFF1; -128*-128 → 0x4000; 127*-1 → 0xFF81.
